// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline boundary register. This is a two-entry skid buffer with a registered in_ready,
// so MEM back-pressure never combinationally reaches EX.
module ex_mem_skid_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] address_EX,
  input  logic [DATA_W-1:0] Rd2_Reg_out_EX,
  input  logic [REG_W-1:0]  Rd_EX,
  input  logic              MemRead_EX,
  input  logic              MemWrite_EX,
  input  logic              RegWrite_EX,
  input  logic              MemToReg_EX,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] address_MEM,
  output logic [DATA_W-1:0] Rd2_Reg_out_MEM,
  output logic [REG_W-1:0]  Rd_MEM,
  output logic              MemRead_MEM,
  output logic              MemWrite_MEM,
  output logic              RegWrite_MEM,
  output logic              MemToReg_MEM,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
  } beat_t;

  state_t state;
  beat_t  main_q;
  beat_t  skid_q;
  beat_t  in_beat;
  logic   accept;
  logic   issue;

  always_comb begin
    in_beat            = '0;
    in_beat.addr       = address_EX;
    in_beat.data       = Rd2_Reg_out_EX;
    in_beat.rd         = Rd_EX;
    in_beat.mem_read   = MemRead_EX;
    in_beat.mem_write  = MemWrite_EX;
    in_beat.reg_write  = RegWrite_EX;
    in_beat.mem_to_reg = MemToReg_EX;
  end

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      stall_count <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_count != '1))
        stall_count <= stall_count + 1'b1;

      // Flush only resets the handshake state; the entries keep their data so
      // the MEM-side data fields hold their last value while invalid.
      if (flush) begin
        state     <= EMPTY;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
      end else begin
        unique case (state)
          EMPTY: begin
            if (accept) begin
              main_q    <= in_beat;
              state     <= BUSY;
              out_valid <= 1'b1;
            end
          end
          BUSY: begin
            if (accept && issue) begin
              main_q <= in_beat;
            end else if (accept) begin
              skid_q   <= in_beat;
              state    <= FULL;
              in_ready <= 1'b0;
            end else if (issue) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
          FULL: begin
            if (issue) begin
              main_q   <= skid_q;
              state    <= BUSY;
              in_ready <= 1'b1;
            end
          end
          default: begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign address_MEM     = main_q.addr;
  assign Rd2_Reg_out_MEM = main_q.data;
  assign Rd_MEM          = main_q.rd;
  assign MemRead_MEM     = main_q.mem_read  & out_valid;
  assign MemWrite_MEM    = main_q.mem_write & out_valid;
  assign RegWrite_MEM    = main_q.reg_write & out_valid;
  assign MemToReg_MEM    = main_q.mem_to_reg;

endmodule
